// File: rtl/fifo_deq_serializer_pkg.sv
// rtl/fifo_deq_serializer_pkg.sv - shared sizing helpers and state type for the FIFO dequeue serializer
package fifo_deq_serializer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } ser_state_t;

    function automatic int num_subs(input int data_width, input int sub_width);
        return data_width / sub_width;
    endfunction

    // The chunk index always needs at least one bit, even for degenerate widths.
    function automatic int idx_width(input int data_width, input int sub_width);
        int n;
        n = data_width / sub_width;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit widths_ok(input int data_width, input int sub_width);
        return (sub_width > 0) && (data_width % sub_width == 0) && (data_width / sub_width >= 2);
    endfunction

endpackage

// File: rtl/fifo_deq_serializer_chunk_sel_mux.sv
// rtl/fifo_deq_serializer_chunk_sel_mux.sv - selects one SUB_WIDTH slice of the held word by index
// Chunk order is reversed (MSB slice first) when FIFO_DEQ_SERIALIZER_MSB_FIRST_EN is defined.
module chunk_sel_mux
    import fifo_deq_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SUB_WIDTH  = 8,
    parameter int IDX_W      = idx_width(DATA_WIDTH, SUB_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]      idx,
    output logic [SUB_WIDTH-1:0]  chunk
);

    localparam int NUM_SUBS = num_subs(DATA_WIDTH, SUB_WIDTH);

    logic [SUB_WIDTH-1:0] slices [NUM_SUBS];

    for (genvar g = 0; g < NUM_SUBS; g++) begin : g_slice
`ifdef FIFO_DEQ_SERIALIZER_MSB_FIRST_EN
        assign slices[g] = data[(NUM_SUBS - 1 - g) * SUB_WIDTH +: SUB_WIDTH];
`else
        assign slices[g] = data[g * SUB_WIDTH +: SUB_WIDTH];
`endif
    end

    assign chunk = slices[idx];

endmodule

// File: rtl/fifo_deq_serializer.sv
// rtl/fifo_deq_serializer.sv - drains full FIFO words and re-emits them as NUM_SUBS narrow chunks
// Optional MSB-first chunk order via FIFO_DEQ_SERIALIZER_MSB_FIRST_EN (applied in chunk_sel_mux).
module fifo_deq_serializer
    import fifo_deq_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SUB_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_aH,
    input  logic                  valid_deq,
    input  logic [DATA_WIDTH-1:0] data_deq,
    output logic                  ready_deq,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [SUB_WIDTH-1:0]  data_out,
    output logic                  last_out
);

    localparam int NUM_SUBS = num_subs(DATA_WIDTH, SUB_WIDTH);
    localparam int IDX_W    = idx_width(DATA_WIDTH, SUB_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SUBS - 1);

    if (!widths_ok(DATA_WIDTH, SUB_WIDTH)) begin : g_bad_widths
        $error("fifo_deq_serializer: DATA_WIDTH must be a multiple of SUB_WIDTH with at least two chunks");
    end

    ser_state_t            state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  full_q;
    logic                  fire_out;
    logic                  fire_in;

    assign full_q    = (state_q == ST_SEND);
    assign valid_out = full_q;
    assign last_out  = full_q && (idx_q == LAST_IDX);
    assign fire_out  = valid_out && ready_out;
    // Taking a new word while the last chunk leaves is what removes the bubble between words.
    assign ready_deq = !full_q || (fire_out && last_out);
    assign fire_in   = valid_deq && ready_deq;

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fire_in) begin
                        hold_q  <= data_deq;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fire_out) begin
                        if (!last_out) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else if (fire_in) begin
                            hold_q <= data_deq;
                            idx_q  <= '0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    chunk_sel_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUB_WIDTH  (SUB_WIDTH),
        .IDX_W      (IDX_W)
    ) u_chunk_sel_mux (
        .data  (hold_q),
        .idx   (idx_q),
        .chunk (data_out)
    );

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// tb/tb_fifo_deq_serializer.sv - queue-based reference model and directed vectors for fifo_deq_serializer
module tb_fifo_deq_serializer;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int NS = DW / SW;

    logic          clk       = 1'b0;
    logic          rst_aH    = 1'b0;
    logic          valid_deq = 1'b0;
    logic [DW-1:0] data_deq  = '0;
    logic          ready_deq;
    logic          valid_out;
    logic          ready_out = 1'b0;
    logic [SW-1:0] data_out;
    logic          last_out;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [SW-1:0] d;
        logic          l;
    } chunk_t;

    chunk_t        exp_q[$];
    logic [DW-1:0] up_q[$];

    logic [7:0] lit2 [4];
    logic [7:0] lit3 [8];
    logic [7:0] lit5 [4];

    logic m_fire_out, m_fire_in;
    logic e_valid, e_ready;

    always #5 clk = ~clk;

    fifo_deq_serializer #(
        .DATA_WIDTH (DW),
        .SUB_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst_aH    (rst_aH),
        .valid_deq (valid_deq),
        .data_deq  (data_deq),
        .ready_deq (ready_deq),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .last_out  (last_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void load_chunks(input logic [DW-1:0] w);
        for (int k = 0; k < NS; k++) begin
`ifdef FIFO_DEQ_SERIALIZER_MSB_FIRST_EN
            exp_q.push_back('{d: w[(NS - 1 - k) * SW +: SW], l: (k == NS - 1)});
`else
            exp_q.push_back('{d: w[k * SW +: SW], l: (k == NS - 1)});
`endif
        end
    endfunction

    // Reference: pending chunks of the held word; one word may be taken when none
    // remain, or when the final one is leaving this cycle.
    always @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            exp_q.delete();
        end else begin
            m_fire_out = (exp_q.size() > 0) && ready_out;
            m_fire_in  = valid_deq && ((exp_q.size() == 0) || ((exp_q.size() == 1) && m_fire_out));
            if (m_fire_out) exp_q.delete(0);
            if (m_fire_in && up_q.size() > 0) load_chunks(up_q.pop_front());
        end
    end

    always @(negedge clk) begin
        #2;
        e_valid = !rst_aH && (exp_q.size() > 0);
        e_ready = rst_aH || (exp_q.size() == 0) || ((exp_q.size() == 1) && ready_out);
        check("model_valid_out", 32'(valid_out), 32'(e_valid));
        check("model_ready_deq", 32'(ready_deq), 32'(e_ready));
        if (rst_aH) begin
            check("model_reset_data_out", 32'(data_out), 32'h0);
            check("model_reset_last_out", 32'(last_out), 32'h0);
        end else if (e_valid) begin
            check("model_data_out", 32'(data_out), 32'(exp_q[0].d));
            check("model_last_out", 32'(last_out), 32'(exp_q[0].l));
        end
    end

    always @(posedge clk) begin
        if (!rst_aH) begin
            compared++;
            assert (!$isunknown({valid_deq, ready_out})) else begin
                mismatched++;
                $display("FAIL x_on_inputs: valid_deq=%b ready_out=%b at t=%0t", valid_deq, ready_out, $time);
            end
        end
    end

    task automatic refresh();
        valid_deq = (up_q.size() > 0);
        data_deq  = (up_q.size() > 0) ? up_q[0] : '0;
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        ready_out = rdy;
        refresh();
        #3;
    endtask

    task automatic beat(input string name, input logic [7:0] d, input logic l);
        check({name, "_valid"}, 32'(valid_out), 32'h1);
        check({name, "_data"}, 32'(data_out), 32'(d));
        check({name, "_last"}, 32'(last_out), 32'(l));
    endtask

    initial begin
`ifdef FIFO_DEQ_SERIALIZER_MSB_FIRST_EN
        lit2 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        lit3 = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};
        lit5 = '{8'h44, 8'h33, 8'h22, 8'h11};
`else
        lit2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        lit3 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        lit5 = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
        rst_aH = 1'b1;
        up_q.push_back(32'hDEADBEEF);
        refresh();

        // Reset held with a word on offer: nothing may be taken or shown.
        repeat (3) begin
            step(1'b0);
            check("rst_valid_out", 32'(valid_out), 32'h0);
            check("rst_last_out", 32'(last_out), 32'h0);
            check("rst_data_out", 32'(data_out), 32'h0);
            check("rst_ready_deq", 32'(ready_deq), 32'h1);
        end
        up_q.delete();
        refresh();
        rst_aH = 1'b0;

        // Single word, streaming.
        up_q.push_back(32'hDDCCBBAA);
        step(1'b1);
        check("w1_idle_valid", 32'(valid_out), 32'h0);
        check("w1_idle_ready_deq", 32'(ready_deq), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            beat("w1_beat", lit2[i], (i == 3));
        end
        check("w1_last_ready_deq", 32'(ready_deq), 32'h1);
        step(1'b1);
        check("w1_after_valid", 32'(valid_out), 32'h0);

        // Two words back to back, no gap between them.
        up_q.push_back(32'h03020100);
        up_q.push_back(32'h07060504);
        step(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            beat("b2b_beat", lit3[i], (i % 4 == 3));
        end
        step(1'b1);
        check("b2b_after_valid", 32'(valid_out), 32'h0);

        // Downstream stall on the second chunk.
        up_q.push_back(32'hDDCCBBAA);
        step(1'b1);
        step(1'b1);
        beat("stall_first", lit2[0], 1'b0);
        repeat (3) begin
            step(1'b0);
            beat("stall_hold", lit2[1], 1'b0);
            check("stall_ready_deq", 32'(ready_deq), 32'h0);
        end
        step(1'b1);
        beat("stall_release", lit2[1], 1'b0);
        step(1'b1);
        beat("stall_next", lit2[2], 1'b0);
        step(1'b1);
        beat("stall_last", lit2[3], 1'b1);
        step(1'b1);
        check("stall_after_valid", 32'(valid_out), 32'h0);

        // Asynchronous reset between edges drops the word in flight.
        up_q.push_back(32'hDDCCBBAA);
        step(1'b1);
        step(1'b1);
        beat("arst_pre", lit2[0], 1'b0);
        rst_aH = 1'b1;
        #1;
        check("arst_valid_out", 32'(valid_out), 32'h0);
        check("arst_last_out", 32'(last_out), 32'h0);
        check("arst_data_out", 32'(data_out), 32'h0);
        check("arst_ready_deq", 32'(ready_deq), 32'h1);
        rst_aH = 1'b0;
        step(1'b1);
        check("arst_idle_valid", 32'(valid_out), 32'h0);
        up_q.push_back(32'h44332211);
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            beat("arst_word", lit5[i], (i == 3));
        end
        step(1'b1);
        check("arst_after_valid", 32'(valid_out), 32'h0);

        step(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
